// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU load/store
// port (0) and the debug/preload DMA port (1); one transaction in flight at a time.
module data_mem_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic              we0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              we1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic              mem_read,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [CNT_W-1:0]  gnt_cnt0,
   output logic [CNT_W-1:0]  gnt_cnt1
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state;
   logic   owner;
   logic   last_grant;
   logic   winner;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      if (&cnt)
         return cnt;
      else
         return cnt + CNT_W'(1);
   endfunction

   // Under contention the port that did not win last time goes next.
   function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
      if (r0 && r1)
         return ~last;
      else
         return r1;
   endfunction

   assign winner = pick_winner(req0, req1, last_grant);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
         rdata      <= '0;
         mem_addr   <= '0;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
         mem_wdata  <= '0;
         gnt_cnt0   <= '0;
         gnt_cnt1   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner      <= winner;
                  last_grant <= winner;
                  busy       <= 1'b1;
                  state      <= ACCESS;
                  if (winner) begin
                     mem_addr  <= addr1;
                     mem_wdata <= wdata1;
                     mem_write <= we1;
                     mem_read  <= ~we1;
                     gnt_cnt1  <= sat_inc(gnt_cnt1);
                  end else begin
                     mem_addr  <= addr0;
                     mem_wdata <= wdata0;
                     mem_write <= we0;
                     mem_read  <= ~we0;
                     gnt_cnt0  <= sat_inc(gnt_cnt0);
                  end
               end
            end
            ACCESS: begin
               // Memory presented read data on the mid-cycle negedge.
               if (mem_read)
                  rdata <= mem_rdata;
               mem_write <= 1'b0;
               mem_read  <= 1'b0;
               ack0      <= ~owner;
               ack1      <= owner;
               state     <= DONE;
            end
            DONE: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               ack0      <= 1'b0;
               ack1      <= 1'b0;
               mem_write <= 1'b0;
               mem_read  <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 128x32 memory
// (writes on posedge, reads on negedge).
module tb_data_mem_arbiter;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic              ack0, ack1, mem_write, mem_read, busy;
   logic [DATA_W-1:0] rdata, mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;

   logic [DATA_W-1:0] mem [128];

   int n_tests = 0;
   int n_fail  = 0;

   data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      if (mem_write) mem[mem_addr] <= mem_wdata;

   always @(negedge clock)
      if (mem_read) mem_rdata <= mem[mem_addr];

   task automatic apply_reset();
      req0 = 1'b0;
      req1 = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   // One transaction on the given port; returns posedges from request to ack (-1 on timeout),
   // number of sampled cycles with mem_write high, and ack pulses seen on the other port.
   task automatic do_txn(input int port, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int lat, output int wcnt,
                         output int other_ack);
      bit got;
      @(posedge clock); #1;
      if (port == 0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
      got = 0; lat = -1; wcnt = 0; other_ack = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(posedge clock); #1;
         if (mem_write) wcnt++;
         if ((port == 0 && ack1) || (port == 1 && ack0)) other_ack++;
         if ((port == 0 && ack0) || (port == 1 && ack1)) begin
            got = 1;
            lat = i;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         n_tests++;
         if ({busy, ack0, ack1, mem_write, mem_read, mem_addr, mem_wdata, rdata,
              gnt_cnt0, gnt_cnt1} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: busy=%b mw=%b mr=%b addr=%h wd=%h rdata=%h c0=%0d c1=%0d, required all zero",
                     i, busy, mem_write, mem_read, mem_addr, mem_wdata, rdata, gnt_cnt0, gnt_cnt1);
         end
      end
   endtask

   task automatic test_port0_write_read();
      int lat, wcnt, oth;
      do_txn(0, 1'b1, 7'd3, 32'hDEADBEEF, lat, wcnt, oth);
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL p0_write_latency: got %0d, required 2", lat); end
      n_tests++;
      if (wcnt !== 1) begin n_fail++; $display("FAIL p0_write_pulse: mem_write high %0d cycles, required 1", wcnt); end
      n_tests++;
      if (mem[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL p0_write_mem: Mem[3]=%h, required deadbeef", mem[3]); end
      n_tests++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL write_keeps_rdata: rdata=%h, required 0", rdata); end
      do_txn(0, 1'b0, 7'd3, 32'h0, lat, wcnt, oth);
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL p0_read_latency: got %0d, required 2", lat); end
      n_tests++;
      if (wcnt !== 0) begin n_fail++; $display("FAIL p0_read_nowrite: mem_write high %0d cycles, required 0", wcnt); end
      n_tests++;
      if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL p0_read_data: rdata=%h, required deadbeef", rdata); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL p0_idle_after: busy=%b, required 0", busy); end
   endtask

   task automatic test_port1_read();
      int lat, wcnt, oth;
      do_txn(1, 1'b0, 7'd7, 32'h0, lat, wcnt, oth);
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL p1_read_latency: got %0d, required 2", lat); end
      n_tests++;
      if (rdata !== 32'd10) begin n_fail++; $display("FAIL p1_read_data: rdata=%h, required 0000000a", rdata); end
      n_tests++;
      if (oth !== 0) begin n_fail++; $display("FAIL p1_no_ack0: ack0 pulses=%0d, required 0", oth); end
   endtask

   task automatic test_alternation();
      int grants[$];
      int exp_seq[6] = '{0, 1, 0, 1, 0, 1};
      bit timeout;
      apply_reset();
      @(posedge clock); #1;
      we0 = 1'b0; addr0 = 7'd3; we1 = 1'b0; addr1 = 7'd7;
      req0 = 1'b1; req1 = 1'b1;
      timeout = 1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clock); #1;
         if (ack0) grants.push_back(0);
         if (ack1) grants.push_back(1);
         if (grants.size() >= 6) begin
            timeout = 0;
            break;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      n_tests++;
      if (timeout) begin
         n_fail++;
         $display("FAIL alt_count: saw %0d grants, required 6", grants.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (grants[i] !== exp_seq[i]) begin
               n_fail++;
               $display("FAIL alt_grant[%0d]: port %0d, required %0d", i, grants[i], exp_seq[i]);
            end
         end
      end
      n_tests++;
      if (gnt_cnt0 !== 4'd3 || gnt_cnt1 !== 4'd3) begin
         n_fail++;
         $display("FAIL alt_counters: c0=%0d c1=%0d, required 3 and 3", gnt_cnt0, gnt_cnt1);
      end
      repeat (2) @(posedge clock);
   endtask

   task automatic test_reset_mid_access();
      bit saw_ack;
      @(posedge clock); #1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 7'd8; wdata1 = 32'h55;
      @(posedge clock); #1;
      n_tests++;
      if (mem_write !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_enter: mem_write=%b busy=%b, required 1 and 1", mem_write, busy);
      end
      #1 reset_n = 1'b0;
      #1;
      n_tests++;
      if (mem_write !== 1'b0 || busy !== 1'b0 || gnt_cnt1 !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_clear: mem_write=%b busy=%b c1=%0d, required 0 0 0", mem_write, busy, gnt_cnt1);
      end
      req1 = 1'b0;
      saw_ack = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         if (ack1) saw_ack = 1;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         if (ack1) saw_ack = 1;
      end
      n_tests++;
      if (saw_ack) begin n_fail++; $display("FAIL rst_mid_noack: ack1 seen=1, required 0"); end
      n_tests++;
      if (mem[8] !== 32'd10) begin n_fail++; $display("FAIL rst_mid_mem: Mem[8]=%h, required 0000000a", mem[8]); end
   endtask

   task automatic test_saturation();
      int lat, wcnt, oth, late;
      apply_reset();
      late = 0;
      for (int i = 0; i < 20; i++) begin
         do_txn(0, 1'b0, 7'd3, 32'h0, lat, wcnt, oth);
         if (lat != 2) late++;
      end
      n_tests++;
      if (late !== 0) begin n_fail++; $display("FAIL sat_latency: %0d bad txns, required 0", late); end
      n_tests++;
      if (gnt_cnt0 !== 4'd15) begin n_fail++; $display("FAIL sat_cnt0: got %0d, required 15", gnt_cnt0); end
      n_tests++;
      if (gnt_cnt1 !== 4'd0) begin n_fail++; $display("FAIL sat_cnt1: got %0d, required 0", gnt_cnt1); end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      mem[7] = 32'd10;
      mem[8] = 32'd10;
      test_reset();
      test_port0_write_read();
      test_port1_read();
      test_alternation();
      test_reset_mid_access();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
